// File: rtl/mul_sequencer_pkg.sv
// Shared definitions for the iterative multiply unit: op codes, FSM states,
// default operand width and a small op-decoding helper.
package mul_sequencer_pkg;

  localparam int WIDTH_DEF = 32;

  localparam logic [1:0] MUL_OP   = 2'b00;
  localparam logic [1:0] UMULL_OP = 2'b01;
  localparam logic [1:0] SMULL_OP = 2'b10;
  localparam logic [1:0] ILL_OP   = 2'b11;

  typedef enum logic [2:0] {
    ST_IDLE = 3'd0,
    ST_CALC = 3'd1,
    ST_SIGN = 3'd2,
    ST_WBLO = 3'd3,
    ST_WBHI = 3'd4
  } state_e;

  // Long multiplies write both halves of the 2*WIDTH product.
  function automatic logic is_long_op(input logic [1:0] op);
    return (op == UMULL_OP) || (op == SMULL_OP);
  endfunction

endpackage

// File: rtl/mul_datapath.sv
// Radix-2 shift-add datapath: operand magnitudes, 2*WIDTH accumulator,
// shifting multiplicand/multiplier, iteration counter and final negation.
module mul_datapath
  import mul_sequencer_pkg::*;
#(
  parameter int WIDTH = WIDTH_DEF
) (
  input  logic               clk,
  input  logic               reset,
  input  logic               load_i,
  input  logic               signed_i,
  input  logic [WIDTH-1:0]   a_i,
  input  logic [WIDTH-1:0]   b_i,
  input  logic               calc_i,
  input  logic               sign_i,
  output logic [2*WIDTH-1:0] acc_fix_o,
  output logic               last_o
);

  localparam int AW    = 2 * WIDTH;
  localparam int CNT_W = $clog2(WIDTH);

  logic [AW-1:0]    acc_q;
  logic [AW-1:0]    mcand_q;
  logic [WIDTH-1:0] mplier_q;
  logic [CNT_W-1:0] cnt_q;
  logic             neg_q;

  logic [WIDTH-1:0] mag_a_s;
  logic [WIDTH-1:0] mag_b_s;

  // Signed operands are converted to magnitudes; 0x80.. maps to 2^(WIDTH-1) unsigned.
  assign mag_a_s = (signed_i && a_i[WIDTH-1]) ? (~a_i + WIDTH'(1)) : a_i;
  assign mag_b_s = (signed_i && b_i[WIDTH-1]) ? (~b_i + WIDTH'(1)) : b_i;

  // Product with the sign restored; this is the value committed in SIGN.
  assign acc_fix_o = neg_q ? (~acc_q + AW'(1)) : acc_q;
  assign last_o    = (cnt_q == CNT_W'(WIDTH - 1));

  // Load operands, iterate shift-add, then apply sign correction.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      acc_q    <= '0;
      mcand_q  <= '0;
      mplier_q <= '0;
      cnt_q    <= '0;
      neg_q    <= 1'b0;
    end else if (load_i) begin
      acc_q    <= '0;
      mcand_q  <= {{WIDTH{1'b0}}, mag_a_s};
      mplier_q <= mag_b_s;
      cnt_q    <= '0;
      neg_q    <= signed_i & (a_i[WIDTH-1] ^ b_i[WIDTH-1]);
    end else if (calc_i) begin
      if (mplier_q[0]) begin
        acc_q <= acc_q + mcand_q;
      end else begin
        acc_q <= acc_q;
      end
      mcand_q  <= mcand_q << 1;
      mplier_q <= mplier_q >> 1;
      cnt_q    <= cnt_q + CNT_W'(1);
    end else if (sign_i) begin
      acc_q <= acc_fix_o;
    end else begin
      acc_q <= acc_q;
    end
  end

endmodule

// File: rtl/mul_sequencer.sv
// Multiply sequencer: accepts MUL/UMULL/SMULL requests, drives the shift-add
// datapath, then writes RdLo (and RdHi for long ops) with optional N/Z flags.
module mul_sequencer
  import mul_sequencer_pkg::*;
#(
  parameter int WIDTH = WIDTH_DEF
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             start,
  input  logic [1:0]       op,
  input  logic             setflags,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic [3:0]       rdlo,
  input  logic [3:0]       rdhi,
  input  logic             flush,
  output logic             busy,
  output logic             done,
  output logic             err,
  output logic             wr_en,
  output logic [3:0]       wr_addr,
  output logic [WIDTH-1:0] wr_data,
  output logic             flag_we,
  output logic [1:0]       flag_nz
);

  state_e           state_q;
  logic [1:0]       op_q;
  logic             setflags_q;
  logic [3:0]       rdlo_q;
  logic [3:0]       rdhi_q;
  logic [WIDTH-1:0] hi_q;
  logic [1:0]       nz_hold_q;
  logic             busy_q;
  logic             wr_en_q;
  logic [3:0]       wr_addr_q;
  logic [WIDTH-1:0] wr_data_q;
  logic             done_q;
  logic             flag_we_q;
  logic [1:0]       flag_nz_q;

  logic               idle_s;
  logic               accept_s;
  logic               long_s;
  logic [2*WIDTH-1:0] acc_fix_s;
  logic               last_s;
  logic [1:0]         nz_s;

  assign idle_s   = (state_q == ST_IDLE);
  assign accept_s = idle_s & start & ~flush & (op != ILL_OP);
  assign long_s   = is_long_op(op_q);

  // N/Z come from the low word for MUL and the full product for long ops.
  assign nz_s = long_s ? {acc_fix_s[2*WIDTH-1], (acc_fix_s == '0)}
                       : {acc_fix_s[WIDTH-1], (acc_fix_s[WIDTH-1:0] == '0)};

  mul_datapath #(.WIDTH(WIDTH)) u_dp (
    .clk       (clk),
    .reset     (reset),
    .load_i    (accept_s),
    .signed_i  (op == SMULL_OP),
    .a_i       (a),
    .b_i       (b),
    .calc_i    (state_q == ST_CALC),
    .sign_i    (state_q == ST_SIGN),
    .acc_fix_o (acc_fix_s),
    .last_o    (last_s)
  );

  // Write strobes are suppressed in the very cycle a flush arrives.
  assign busy    = busy_q;
  assign wr_en   = wr_en_q & ~flush;
  assign wr_addr = wr_addr_q;
  assign wr_data = wr_data_q;
  assign done    = done_q & ~flush;
  assign flag_we = flag_we_q & ~flush;
  assign flag_nz = flush ? 2'b00 : flag_nz_q;
  // Illegal op is reported in the same cycle the request is presented.
  assign err     = ~reset & idle_s & start & ~flush & (op == ILL_OP);

  // Control FSM with registered writeback outputs aligned to their states.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q    <= ST_IDLE;
      op_q       <= 2'b00;
      setflags_q <= 1'b0;
      rdlo_q     <= 4'd0;
      rdhi_q     <= 4'd0;
      hi_q       <= '0;
      nz_hold_q  <= 2'b00;
      busy_q     <= 1'b0;
      wr_en_q    <= 1'b0;
      wr_addr_q  <= 4'd0;
      wr_data_q  <= '0;
      done_q     <= 1'b0;
      flag_we_q  <= 1'b0;
      flag_nz_q  <= 2'b00;
    end else if (flush && !idle_s) begin
      state_q   <= ST_IDLE;
      busy_q    <= 1'b0;
      wr_en_q   <= 1'b0;
      wr_addr_q <= 4'd0;
      wr_data_q <= '0;
      done_q    <= 1'b0;
      flag_we_q <= 1'b0;
      flag_nz_q <= 2'b00;
    end else begin
      wr_en_q   <= 1'b0;
      wr_addr_q <= 4'd0;
      wr_data_q <= '0;
      done_q    <= 1'b0;
      flag_we_q <= 1'b0;
      flag_nz_q <= 2'b00;
      case (state_q)
        ST_IDLE: begin
          if (accept_s) begin
            state_q    <= ST_CALC;
            op_q       <= op;
            setflags_q <= setflags;
            rdlo_q     <= rdlo;
            rdhi_q     <= rdhi;
            busy_q     <= 1'b1;
          end else begin
            state_q <= ST_IDLE;
            busy_q  <= 1'b0;
          end
        end
        ST_CALC: begin
          if (last_s) begin
            state_q <= ST_SIGN;
          end else begin
            state_q <= ST_CALC;
          end
        end
        ST_SIGN: begin
          state_q   <= ST_WBLO;
          wr_en_q   <= 1'b1;
          wr_addr_q <= rdlo_q;
          wr_data_q <= acc_fix_s[WIDTH-1:0];
          hi_q      <= acc_fix_s[2*WIDTH-1:WIDTH];
          nz_hold_q <= nz_s;
          if (!long_s) begin
            done_q    <= 1'b1;
            flag_we_q <= setflags_q;
            flag_nz_q <= setflags_q ? nz_s : 2'b00;
          end else begin
            done_q <= 1'b0;
          end
        end
        ST_WBLO: begin
          if (long_s) begin
            state_q   <= ST_WBHI;
            wr_en_q   <= 1'b1;
            wr_addr_q <= rdhi_q;
            wr_data_q <= hi_q;
            done_q    <= 1'b1;
            flag_we_q <= setflags_q;
            flag_nz_q <= setflags_q ? nz_hold_q : 2'b00;
          end else begin
            state_q <= ST_IDLE;
            busy_q  <= 1'b0;
          end
        end
        ST_WBHI: begin
          state_q <= ST_IDLE;
          busy_q  <= 1'b0;
        end
        default: begin
          state_q <= ST_IDLE;
          busy_q  <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_mul_sequencer.sv
// Directed self-checking bench for mul_sequencer: a negedge monitor logs every
// register write / done / flag pulse with its cycle number, and the linear
// stimulus compares the log and live outputs against hand-computed values.
module tb_mul_sequencer;
  import mul_sequencer_pkg::*;

  localparam int W = 32;

  logic         clk = 1'b0;
  logic         reset, start, setflags, flush;
  logic [1:0]   op;
  logic [W-1:0] a, b;
  logic [3:0]   rdlo, rdhi;
  logic         busy, done, err, wr_en, flag_we;
  logic [3:0]   wr_addr;
  logic [W-1:0] wr_data;
  logic [1:0]   flag_nz;

  int checks = 0;
  int errors = 0;
  int cyc = 0;
  int t;

  logic [3:0]   wa[$];
  logic [W-1:0] wd[$];
  int           wc[$];
  int           ndone, done_cyc, nflag, busy_cnt, nerr;
  logic [1:0]   last_nz;

  mul_sequencer #(.WIDTH(W)) dut (
    .clk(clk), .reset(reset), .start(start), .op(op), .setflags(setflags),
    .a(a), .b(b), .rdlo(rdlo), .rdhi(rdhi), .flush(flush),
    .busy(busy), .done(done), .err(err), .wr_en(wr_en), .wr_addr(wr_addr),
    .wr_data(wr_data), .flag_we(flag_we), .flag_nz(flag_nz)
  );

  always #5 clk = ~clk;

  // Cycle counter referenced by the monitor.
  always @(posedge clk) cyc <= cyc + 1;

  // Monitor: log output events mid-cycle.
  always @(negedge clk) begin
    if (wr_en) begin
      wa.push_back(wr_addr);
      wd.push_back(wr_data);
      wc.push_back(cyc);
    end
    if (done) begin
      ndone++;
      done_cyc = cyc;
    end
    if (flag_we) begin
      nflag++;
      last_nz = flag_nz;
    end
    if (busy) busy_cnt++;
    if (err) nerr++;
  end

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic tick(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic clear_log();
    wa.delete(); wd.delete(); wc.delete();
    ndone = 0; done_cyc = -1; nflag = 0; busy_cnt = 0; nerr = 0; last_nz = 2'b00;
  endtask

  // Present one request for one cycle; tstart is the cycle start is high.
  task automatic go(input logic [1:0] o, input logic [W-1:0] va, input logic [W-1:0] vb,
                    input logic [3:0] lo, input logic [3:0] hi, input logic sf,
                    output int tstart);
    op = o; a = va; b = vb; rdlo = lo; rdhi = hi; setflags = sf;
    start = 1'b1;
    tstart = cyc;
    tick(1);
    start = 1'b0;
  endtask

  initial begin
    reset = 1'b1; start = 1'b0; setflags = 1'b0; flush = 1'b0;
    op = 2'b00; a = '0; b = '0; rdlo = 4'd0; rdhi = 4'd0;
    clear_log();
    tick(2);
    chk("reset_busy", 64'(busy), 64'd0);
    chk("reset_outs", 64'({done, err, wr_en, flag_we, flag_nz, wr_addr}), 64'd0);
    chk("reset_data", 64'(wr_data), 64'd0);
    reset = 1'b0;
    tick(2);

    // 1: MUL 7*6 -> r3 = 42 at t+34, busy t+1..t+34
    clear_log();
    go(MUL_OP, 32'd7, 32'd6, 4'd3, 4'd0, 1'b0, t);
    @(negedge clk);
    chk("mul_busy_t1", 64'(busy), 64'd1);
    tick(40);
    chk("mul_nwr", 64'(wa.size()), 64'd1);
    chk("mul_addr", 64'(wa[0]), 64'd3);
    chk("mul_data", 64'(wd[0]), 64'h2A);
    chk("mul_wcyc", 64'(wc[0]), 64'(t + 34));
    chk("mul_done_cyc", 64'(done_cyc), 64'(t + 34));
    chk("mul_ndone", 64'(ndone), 64'd1);
    chk("mul_busy_len", 64'(busy_cnt), 64'd34);
    chk("mul_nflag", 64'(nflag), 64'd0);

    // 2: UMULL FFFFFFFF^2 = FFFFFFFE_00000001, flags N=1 Z=0
    clear_log();
    go(UMULL_OP, 32'hFFFFFFFF, 32'hFFFFFFFF, 4'd1, 4'd2, 1'b1, t);
    tick(40);
    chk("umull_nwr", 64'(wa.size()), 64'd2);
    chk("umull_lo", 64'({wa[0], wd[0]}), {28'd0, 4'd1, 32'h00000001});
    chk("umull_hi", 64'({wa[1], wd[1]}), {28'd0, 4'd2, 32'hFFFFFFFE});
    chk("umull_lo_cyc", 64'(wc[0]), 64'(t + 34));
    chk("umull_hi_cyc", 64'(wc[1]), 64'(t + 35));
    chk("umull_done_cyc", 64'(done_cyc), 64'(t + 35));
    chk("umull_nflag", 64'(nflag), 64'd1);
    chk("umull_nz", 64'(last_nz), 64'd2);
    chk("umull_busy_len", 64'(busy_cnt), 64'd35);

    // 3a: SMULL -2*3 = -6
    clear_log();
    go(SMULL_OP, 32'hFFFFFFFE, 32'd3, 4'd4, 4'd5, 1'b0, t);
    tick(40);
    chk("smull_neg_lo", 64'(wd[0]), 64'hFFFFFFFA);
    chk("smull_neg_hi", 64'(wd[1]), 64'hFFFFFFFF);
    chk("smull_neg_nflag", 64'(nflag), 64'd0);

    // 3b: SMULL 0x80000000^2 = 2^62, rdlo==rdhi so both land on r7
    clear_log();
    go(SMULL_OP, 32'h80000000, 32'h80000000, 4'd7, 4'd7, 1'b0, t);
    tick(40);
    chk("smull_min_nwr", 64'(wa.size()), 64'd2);
    chk("smull_min_lo", 64'({wa[0], wd[0]}), {28'd0, 4'd7, 32'h00000000});
    chk("smull_min_hi", 64'({wa[1], wd[1]}), {28'd0, 4'd7, 32'h40000000});

    // 4: UMULL 0*x with flags Z=1; a second start while busy is dropped
    clear_log();
    go(UMULL_OP, 32'd0, 32'h12345678, 4'd10, 4'd11, 1'b1, t);
    tick(5);
    op = MUL_OP; a = 32'd1; b = 32'd1; rdlo = 4'd9; start = 1'b1;
    tick(1);
    start = 1'b0;
    tick(45);
    chk("zero_nwr", 64'(wa.size()), 64'd2);
    chk("zero_lo", 64'({wa[0], wd[0]}), {28'd0, 4'd10, 32'd0});
    chk("zero_hi", 64'({wa[1], wd[1]}), {28'd0, 4'd11, 32'd0});
    chk("zero_nz", 64'(last_nz), 64'd1);
    chk("zero_ndone", 64'(ndone), 64'd1);

    // 5: flush at t+10 of a UMULL, then a fresh MUL 5*5 at t+11
    clear_log();
    go(UMULL_OP, 32'd9, 32'd9, 4'd12, 4'd13, 1'b1, t);
    tick(9);
    flush = 1'b1;
    tick(1);
    flush = 1'b0;
    chk("flush_idle", 64'(busy), 64'd0);
    chk("flush_cyc", 64'(cyc), 64'(t + 11));
    go(MUL_OP, 32'd5, 32'd5, 4'd8, 4'd0, 1'b0, t);
    tick(40);
    chk("flush_nwr", 64'(wa.size()), 64'd1);
    chk("flush_fresh", 64'({wa[0], wd[0]}), {28'd0, 4'd8, 32'd25});
    chk("flush_fresh_cyc", 64'(wc[0]), 64'(t + 34));
    chk("flush_ndone", 64'(ndone), 64'd1);
    chk("flush_nflag", 64'(nflag), 64'd0);

    // 5b: flush landing on the MUL writeback cycle suppresses it
    clear_log();
    go(MUL_OP, 32'd3, 32'd3, 4'd14, 4'd0, 1'b1, t);
    tick(33);
    flush = 1'b1;
    @(negedge clk);
    chk("flush_wb_outs", 64'({wr_en, done, flag_we}), 64'd0);
    tick(1);
    flush = 1'b0;
    chk("flush_wb_idle", 64'(busy), 64'd0);
    tick(5);
    chk("flush_wb_nwr", 64'(wa.size()), 64'd0);
    chk("flush_wb_ndone", 64'(ndone), 64'd0);

    // 6: reset mid-CALC, then an illegal op
    clear_log();
    go(UMULL_OP, 32'd100, 32'd200, 4'd1, 4'd2, 1'b1, t);
    tick(10);
    reset = 1'b1;
    #1;
    chk("rst_mid_outs", 64'({busy, done, wr_en, flag_we, err}), 64'd0);
    tick(2);
    reset = 1'b0;
    tick(40);
    chk("rst_mid_nwr", 64'(wa.size()), 64'd0);
    chk("rst_mid_ndone", 64'(ndone), 64'd0);
    clear_log();
    op = ILL_OP; start = 1'b1;
    @(negedge clk);
    chk("ill_err", 64'(err), 64'd1);
    chk("ill_busy", 64'(busy), 64'd0);
    tick(1);
    start = 1'b0; op = MUL_OP;
    @(negedge clk);
    chk("ill_err_clr", 64'(err), 64'd0);
    chk("ill_busy_after", 64'(busy), 64'd0);
    tick(3);
    chk("ill_nerr", 64'(nerr), 64'd1);
    chk("ill_nwr", 64'(wa.size()), 64'd0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
